// File: rtl/boot_loader.sv
// Serial boot loader: parses 'L' (load) and 'G' (go) commands from the UART,
// writes load images into the byte RAM while the CPU is held, answers ACK/NAK.
module boot_loader #(
   parameter int unsigned ADDR_W  = 12,
   parameter int unsigned TIMEOUT = 1000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic [7:0]        resp_data,
   output logic              resp_valid,
   input  logic              resp_ready,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_data,
   input  logic              cpu_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_data,
   output logic              mem_we,
   output logic              cpu_hold,
   output logic              busy
);

   localparam int unsigned   TMO_W    = 24;
   localparam logic [7:0]    CMD_LOAD = 8'h4C;
   localparam logic [7:0]    CMD_GO   = 8'h47;
   localparam logic [7:0]    RSP_ACK  = 8'h06;
   localparam logic [7:0]    RSP_NAK  = 8'h15;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR_H, S_ADDR_L, S_LEN, S_DATA, S_CSUM, S_RESP
   } state_t;

   state_t              state_q, state_d;
   logic                hold_q, hold_d;
   logic                busy_q, busy_d;
   logic                resp_valid_q, resp_valid_d;
   logic [7:0]          resp_data_q, resp_data_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [7:0]          wr_data_q, wr_data_d;
   logic                wr_we_q, wr_we_d;
   logic [7:0]          count_q, count_d;
   logic [7:0]          csum_q, csum_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;

   logic                in_cmd_c;
   logic                tmo_expire_c;
   logic [7:0]          csum_sum_c;

   assign in_cmd_c     = state_q inside {S_ADDR_H, S_ADDR_L, S_LEN, S_DATA, S_CSUM};
   assign tmo_expire_c = in_cmd_c && !rx_valid && (tmo_q == TMO_LAST);
   assign csum_sum_c   = csum_q + rx_data;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         hold_q       <= 1'b1;
         busy_q       <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= 8'h00;
         addr_q       <= '0;
         wr_addr_q    <= '0;
         wr_data_q    <= 8'h00;
         wr_we_q      <= 1'b0;
         count_q      <= 8'h00;
         csum_q       <= 8'h00;
         tmo_q        <= '0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         busy_q       <= busy_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         addr_q       <= addr_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         wr_we_q      <= wr_we_d;
         count_q      <= count_d;
         csum_q       <= csum_d;
         tmo_q        <= tmo_d;
      end
   end

   // Command sequencing; an idle gap inside a command aborts to RESP.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (rx_valid) state_d = (rx_data == CMD_LOAD) ? S_ADDR_H : S_RESP;
         S_ADDR_H: if (rx_valid) state_d = S_ADDR_L; else if (tmo_expire_c) state_d = S_RESP;
         S_ADDR_L: if (rx_valid) state_d = S_LEN;    else if (tmo_expire_c) state_d = S_RESP;
         S_LEN:    if (rx_valid) state_d = S_DATA;   else if (tmo_expire_c) state_d = S_RESP;
         S_DATA: begin
            if (rx_valid) begin
               if (count_q == 8'd1) state_d = S_CSUM;
            end else if (tmo_expire_c) begin
               state_d = S_RESP;
            end
         end
         S_CSUM:   if (rx_valid) state_d = S_RESP;   else if (tmo_expire_c) state_d = S_RESP;
         S_RESP:   if (resp_ready) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      hold_d       = hold_q;
      busy_d       = (state_d != S_IDLE);
      resp_valid_d = resp_valid_q;
      resp_data_d  = resp_data_q;
      addr_d       = addr_q;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      wr_we_d      = 1'b0;
      count_d      = count_q;
      csum_d       = csum_q;
      tmo_d        = tmo_q;

      if (in_cmd_c) begin
         tmo_d = rx_valid ? '0 : tmo_q + TMO_W'(1);
         if (rx_valid) csum_d = csum_sum_c;
         if (tmo_expire_c) begin
            resp_valid_d = 1'b1;
            resp_data_d  = RSP_NAK;
         end
      end

      unique case (state_q)
         S_IDLE: begin
            if (rx_valid) begin
               if (rx_data == CMD_LOAD) begin
                  hold_d = 1'b1;
                  csum_d = 8'h00;
                  tmo_d  = '0;
               end else begin
                  resp_valid_d = 1'b1;
                  resp_data_d  = (rx_data == CMD_GO) ? RSP_ACK : RSP_NAK;
                  if (rx_data == CMD_GO) hold_d = 1'b0;
               end
            end
         end
         // Upper address bits beyond ADDR_W fall off in the width cast.
         S_ADDR_H: if (rx_valid) addr_d = ADDR_W'({rx_data, 8'h00});
         S_ADDR_L: if (rx_valid) addr_d = addr_q | ADDR_W'(rx_data);
         S_LEN:    if (rx_valid) count_d = rx_data;
         S_DATA: begin
            if (rx_valid) begin
               wr_we_d   = 1'b1;
               wr_addr_d = addr_q;
               wr_data_d = rx_data;
               addr_d    = addr_q + ADDR_W'(1);
               count_d   = count_q - 8'd1;
            end
         end
         S_CSUM: begin
            if (rx_valid) begin
               resp_valid_d = 1'b1;
               resp_data_d  = (csum_sum_c == 8'h00) ? RSP_ACK : RSP_NAK;
            end
         end
         S_RESP:   if (resp_ready) resp_valid_d = 1'b0;
         default: ;
      endcase
   end

   assign mem_addr   = hold_q ? wr_addr_q : cpu_addr;
   assign mem_data   = hold_q ? wr_data_q : cpu_data;
   assign mem_we     = hold_q ? wr_we_q   : cpu_we;
   assign cpu_hold   = hold_q;
   assign busy       = busy_q;
   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: frame-level reference model checked every cycle,
// directed literal cases plus randomized command traffic.
module tb_boot_loader;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  resp_data;
   logic        resp_valid;
   logic        resp_ready;
   logic [11:0] cpu_addr;
   logic [7:0]  cpu_data;
   logic        cpu_we;
   logic [11:0] mem_addr;
   logic [7:0]  mem_data;
   logic        mem_we;
   logic        cpu_hold;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   boot_loader #(.ADDR_W(12), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .resp_data(resp_data), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_we(cpu_we),
      .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
      .cpu_hold(cpu_hold), .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference model: command progress tracked as the list of bytes received so far.
   bit          m_in_cmd = 0, m_pending = 0, m_hold = 1, e_we = 0;
   logic [7:0]  m_resp = 8'h00, e_data = 8'h00;
   logic [11:0] e_addr = 12'h000;
   logic [7:0]  m_frame[$];
   int          m_idle = 0;

   bit          chk_en = 0, rr_rand = 0, rr_val = 1, cpu_rand = 0;
   logic [19:0] wlog[$];
   logic [7:0]  rlog[$];
   logic [19:0] exp_w[$];
   logic [7:0]  tx_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      int n;
      int len;
      logic [7:0] s;
      if (reset) begin
         m_in_cmd = 0; m_pending = 0; m_hold = 1; e_we = 0;
         m_resp = 8'h00; m_idle = 0; m_frame.delete();
         return;
      end
      e_we = 0;
      if (m_pending) begin
         if (resp_ready) m_pending = 0;
      end else if (!m_in_cmd) begin
         if (rx_valid) begin
            if (rx_data == 8'h4C) begin
               m_in_cmd = 1; m_hold = 1; m_idle = 0; m_frame.delete();
            end else begin
               m_pending = 1;
               m_resp = (rx_data == 8'h47) ? 8'h06 : 8'h15;
               if (rx_data == 8'h47) m_hold = 0;
            end
         end
      end else if (rx_valid) begin
         m_idle = 0;
         m_frame.push_back(rx_data);
         n = m_frame.size();
         if (n >= 4) begin
            len = (m_frame[2] == 8'h00) ? 256 : int'(m_frame[2]);
            if (n <= 3 + len) begin
               e_we   = 1;
               e_addr = 12'({m_frame[0], m_frame[1]}) + 12'(n - 4);
               e_data = rx_data;
            end else begin
               s = 8'h00;
               foreach (m_frame[i]) s += m_frame[i];
               m_resp = (s == 8'h00) ? 8'h06 : 8'h15;
               m_pending = 1;
               m_in_cmd = 0;
            end
         end
      end else begin
         m_idle++;
         if (m_idle >= TMO) begin
            m_in_cmd = 0; m_pending = 1; m_resp = 8'h15;
         end
      end
   endtask

   initial forever begin
      @(posedge clk or posedge reset);
      model_step();
   end

   // Per-cycle comparison against the model, plus write/response logs.
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("cpu_hold", 32'(cpu_hold), 32'(m_hold));
         chk("busy", 32'(busy), 32'(m_in_cmd || m_pending));
         chk("resp_valid", 32'(resp_valid), 32'(m_pending));
         chk("resp_data", 32'(resp_data), 32'(m_resp));
         if (m_hold) begin
            chk("mem_we", 32'(mem_we), 32'(e_we));
            if (e_we) begin
               chk("mem_addr", 32'(mem_addr), 32'(e_addr));
               chk("mem_data", 32'(mem_data), 32'(e_data));
            end
         end else begin
            chk("pass_addr", 32'(mem_addr), 32'(cpu_addr));
            chk("pass_data", 32'(mem_data), 32'(cpu_data));
            chk("pass_we", 32'(mem_we), 32'(cpu_we));
         end
      end
      if (resp_valid && resp_ready) rlog.push_back(resp_data);
      if (mem_we && cpu_hold) wlog.push_back({mem_addr, mem_data});
   end

   task automatic tick();
      @(posedge clk);
      #1;
      rx_valid   = 1'b0;
      resp_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_val;
      if (cpu_rand) begin
         cpu_addr = 12'($urandom);
         cpu_data = 8'($urandom);
         cpu_we   = 1'($urandom);
      end
   endtask

   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
   endtask

   // stall_at >= 0 inserts a gap longer than the timeout before that byte.
   task automatic send_q(input int max_gap, input int stall_at);
      foreach (tx_q[i]) begin
         if (i == stall_at) repeat (TMO + 2) tick();
         send(tx_q[i]);
         repeat ($urandom_range(0, max_gap)) tick();
      end
   endtask

   task automatic wait_idle();
      int t = 0;
      while ((m_in_cmd || m_pending) && t < 3000) begin
         tick();
         t++;
      end
      if (m_in_cmd || m_pending) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_idle: response not completed after %0d cycles", t);
      end
   endtask

   task automatic chk_logs(input string tag, input logic [7:0] rsp);
      chk({tag, "_nwrites"}, 32'(wlog.size()), 32'(exp_w.size()));
      for (int i = 0; i < exp_w.size(); i++)
         if (i < wlog.size()) chk($sformatf("%s_write%0d", tag, i), 32'(wlog[i]), 32'(exp_w[i]));
      chk({tag, "_nresp"}, 32'(rlog.size()), 32'd1);
      chk({tag, "_resp"}, rlog.size() > 0 ? 32'(rlog[rlog.size()-1]) : 32'hDEAD, 32'(rsp));
   endtask

   task automatic run_frame(input string tag, input logic [7:0] rsp);
      wlog.delete();
      rlog.delete();
      send_q(0, -1);
      wait_idle();
      chk_logs(tag, rsp);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; resp_ready = 1'b1;
      cpu_addr = 12'h3A5; cpu_data = 8'hC3; cpu_we = 1'b1;
      #2 reset = 1'b1;
      chk_en = 1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_hold", 32'(cpu_hold), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_data", 32'(resp_data), 32'h00);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      repeat (2) tick();
      chk("idle_mem_we", 32'(mem_we), 32'd0);

      tx_q = '{8'h4C, 8'h00, 8'h10, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hBC};
      exp_w = '{{12'h010, 8'hAA}, {12'h011, 8'hBB}, {12'h012, 8'hCC}};
      run_frame("load_ok", 8'h06);
      tx_q[7] = 8'h57;
      run_frame("load_badsum", 8'h15);

      tx_q = '{8'h4C, 8'h0F, 8'hFF, 8'h02, 8'h11, 8'h22, 8'hBD};
      exp_w = '{{12'hFFF, 8'h11}, {12'h000, 8'h22}};
      run_frame("wrap", 8'h06);
      tx_q = '{8'h4C, 8'hFF, 8'hFF, 8'h02, 8'h11, 8'h22, 8'hCD};
      run_frame("wrap_ffh", 8'h06);

      tx_q = '{8'h47};
      exp_w.delete();
      run_frame("go", 8'h06);
      chk("go_hold", 32'(cpu_hold), 32'd0);
      cpu_addr = 12'h123; cpu_data = 8'h5A; cpu_we = 1'b1;
      #1;
      chk("go_mem_addr", 32'(mem_addr), 32'h123);
      chk("go_mem_data", 32'(mem_data), 32'h5A);
      chk("go_mem_we", 32'(mem_we), 32'd1);
      send(8'h4C);
      chk("reload_hold", 32'(cpu_hold), 32'd1);
      chk("reload_mem_we", 32'(mem_we), 32'd0);

      rr_val = 0;
      send(8'h00);
      repeat (TMO - 1) tick();
      chk("tmo_not_yet", 32'(resp_valid), 32'd0);
      tick();
      chk("tmo_valid", 32'(resp_valid), 32'd1);
      chk("tmo_data", 32'(resp_data), 32'h15);
      repeat (5) begin
         tick();
         chk("stall_valid", 32'(resp_valid), 32'd1);
         chk("stall_data", 32'(resp_data), 32'h15);
      end
      rr_val = 1;
      repeat (2) tick();
      chk("tmo_done_busy", 32'(busy), 32'd0);
      chk("tmo_done_valid", 32'(resp_valid), 32'd0);
      chk("tmo_done_hold", 32'(cpu_hold), 32'd1);

      foreach (tx_q[i]) tx_q[i] = 8'h00;
      tx_q = '{8'h4C, 8'h00, 8'h10, 8'h05, 8'hAA, 8'hBB};
      send_q(0, -1);
      reset = 1'b1;
      #1;
      chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("mid_rst_mem_we", 32'(mem_we), 32'd0);
      chk("mid_rst_hold", 32'(cpu_hold), 32'd1);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      tick();
      reset = 1'b0;
      tick();
      tx_q = '{8'h00};
      exp_w.delete();
      run_frame("unknown", 8'h15);

      rr_rand = 1;
      cpu_rand = 1;
      for (int it = 0; it < 200; it++) begin
         int k;
         k = $urandom_range(0, 99);
         if (k < 65) begin
            int len;
            logic [7:0] s;
            len = ($urandom_range(0, 19) == 0) ? 256 : $urandom_range(1, 6);
            tx_q = '{8'h4C, 8'($urandom), 8'($urandom), 8'(len)};
            for (int j = 0; j < len; j++) tx_q.push_back(8'($urandom));
            s = 8'h00;
            for (int j = 1; j < tx_q.size(); j++) s += tx_q[j];
            tx_q.push_back(($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'(8'h00 - s));
            send_q(2, ($urandom_range(0, 9) == 0) ? $urandom_range(1, 4) : -1);
         end else if (k < 75) begin
            send(8'h47);
         end else if (k < 85) begin
            send(8'($urandom));
         end else if (k < 92) begin
            tx_q = '{8'h4C, 8'($urandom), 8'($urandom), 8'h04, 8'($urandom)};
            send_q(1, -1);
            reset = 1'b1;
            tick();
            reset = 1'b0;
         end else begin
            repeat ($urandom_range(2, 6)) send(8'($urandom));
         end
         if ($urandom_range(0, 4) != 0) wait_idle();
      end
      wait_idle();
      repeat (3) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
